// File: rtl/lt_compare_arbiter_pkg.sv
// Shared definitions for the round-robin less-than compare arbiter:
// datapath width, FSM states and the signed-compare operand bias.
package lt_compare_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [DATA_W-1:0] bias_sign(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
    return {v[DATA_W-1] ^ is_signed, v[DATA_W-2:0]};
  endfunction

endpackage

// File: rtl/lt_compare_arbiter_lt32_core.sv
// Combinational exact unsigned a < b over the full datapath width.
module lt32_core
  import lt_compare_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_lt
);

  assign o_lt = (i_a < i_b);

endmodule

// File: rtl/lt_compare_arbiter.sv
// Shares one 32-bit less-than comparator among NREQ requesters with a
// round-robin grant; results return tagged with the requester index.
module lt_compare_arbiter
  import lt_compare_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ-1:0]          req_signed,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_lt,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         resp_count
);

  state_t            r_state, w_next;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [DATA_W-1:0] r_a, r_b;
  logic              r_signed;
  logic [ID_W-1:0]   r_gid;
  logic              r_rsp_valid, r_rsp_lt;
  logic [ID_W-1:0]   r_rsp_id;
  logic [CNT_W-1:0]  r_count;

  logic [ID_W-1:0]   w_pick_idx;
  logic              w_pick_found;
  logic              w_grant_en;
  logic [DATA_W-1:0] w_sel_a, w_sel_b, w_core_a, w_core_b;
  logic              w_core_lt;

  // First valid requester strictly after r_rr_ptr, wrapping.
  always_comb begin
    logic [ID_W-1:0] cand;
    w_pick_idx   = '0;
    w_pick_found = 1'b0;
    cand         = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = ID_W'((32'(r_rr_ptr) + k) % NREQ);
      if (!w_pick_found && req_valid[cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = cand;
      end
    end
  end

  assign w_grant_en = reset_n && w_pick_found &&
                      ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));
  assign req_ready  = w_grant_en ? (NREQ'(1) << w_pick_idx) : '0;

  assign w_sel_a = req_a[32'(w_pick_idx) * DATA_W +: DATA_W];
  assign w_sel_b = req_b[32'(w_pick_idx) * DATA_W +: DATA_W];

  assign w_core_a = bias_sign(r_a, r_signed);
  assign w_core_b = bias_sign(r_b, r_signed);

  lt32_core u_core (
    .i_a  (w_core_a),
    .i_b  (w_core_b),
    .o_lt (w_core_lt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_grant_en) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = w_grant_en ? ST_EXEC : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // rsp_valid drops on every completed handshake, including a back-to-back
  // regrant, so the EXEC cycle never re-presents an already consumed result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_ptr    <= ID_W'(NREQ - 1);
      r_a         <= '0;
      r_b         <= '0;
      r_signed    <= 1'b0;
      r_gid       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_lt    <= 1'b0;
      r_rsp_id    <= '0;
      r_count     <= '0;
    end else begin
      if (w_grant_en) begin
        r_a      <= w_sel_a;
        r_b      <= w_sel_b;
        r_signed <= req_signed[w_pick_idx];
        r_gid    <= w_pick_idx;
        r_rr_ptr <= w_pick_idx;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_lt    <= w_core_lt;
        r_rsp_id    <= r_gid;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == ST_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_count     <= r_count + CNT_W'(1);
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_lt     = r_rsp_lt;
  assign rsp_id     = r_rsp_id;
  assign busy       = (r_state != ST_IDLE);
  assign resp_count = r_count;

endmodule

// File: tb/tb_lt_compare_arbiter.sv
// Scoreboard bench for lt_compare_arbiter: transaction-level reference model,
// directed corner cases followed by randomized traffic.
module tb_lt_compare_arbiter;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*32-1:0]    req_a, req_b;
  logic [NREQ-1:0]       req_signed;
  logic                  rsp_valid, rsp_ready, rsp_lt, busy;
  logic [ID_W-1:0]       rsp_id;
  logic [CNT_W-1:0]      resp_count;

  lt_compare_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_lt     (rsp_lt),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .resp_count (resp_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            lt;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model state: one outstanding op, its age in cycles since accept.
  bit   m_pend = 0;
  int   m_age  = 0;
  int   m_last = NREQ - 1;
  int   m_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (s) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      chk("req_ready_in_reset", 64'(req_ready), 64'd0);
      q.delete();
      m_pend = 0;
      m_age  = 0;
      m_last = NREQ - 1;
      m_cnt  = 0;
    end else begin
      logic [NREQ-1:0] er;
      int              g;
      bit              can_accept, out_ok;
      exp_t            e;
      out_ok     = m_pend && (m_age >= 2);
      can_accept = !m_pend || (out_ok && rsp_ready);
      g = -1;
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
      er = (can_accept && g >= 0) ? (NREQ'(1) << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rsp_valid", 64'(rsp_valid), 64'(out_ok));
      chk("busy", 64'(busy), 64'(m_pend));
      chk("resp_count", 64'(resp_count), 64'(m_cnt));
      if (out_ok) begin
        if (q.size() == 0) chk("queue_underflow", 64'd1, 64'd0);
        else begin
          chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
          chk("rsp_lt", 64'(rsp_lt), 64'(q[0].lt));
        end
        if (rsp_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          m_cnt  = (m_cnt + 1) % (1 << CNT_W);
          m_pend = 0;
        end
      end
      if (er != '0) begin
        e.id = ID_W'(g);
        e.lt = ref_lt(req_a[32*g +: 32], req_b[32*g +: 32], req_signed[g]);
        q.push_back(e);
        m_pend = 1;
        m_age  = 1;
        m_last = g;
      end else if (m_pend) begin
        m_age++;
      end
    end
  end

  task automatic tick(output logic [NREQ-1:0] hs);
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_signed[i]     = s;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_hs(input int i);
    logic [NREQ-1:0] hs;
    int n = 0;
    do begin
      tick(hs);
      n++;
    end while (!hs[i] && n < 50);
    if (!hs[i]) chk("grant_timeout", 64'd0, 64'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [NREQ-1:0] hs;
    for (int k = 0; k < n; k++) tick(hs);
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_rnd(input int i);
    logic [31:0] a, b;
    a = rnd_word();
    b = ($urandom_range(0, 7) == 0) ? a : rnd_word();
    set_req(i, a, b, 1'($urandom_range(0, 1)));
  endtask

  logic [31:0] dir_a [9] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                             32'h8000_0000, 32'h1234_5678, 32'h0001_0000,
                             32'h0000_FFFF, 32'h8000_0000};
  logic [31:0] dir_b [9] = '{32'd7, 32'd1, 32'd1, 32'h7FFF_FFFF,
                             32'h8000_0001, 32'h1234_5678, 32'h0000_FFFF,
                             32'h0001_0000, 32'h7FFF_FFFF};
  logic        dir_s [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [NREQ-1:0] hs;
    int n;
    reset_n    = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    rsp_ready  = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Single-request corners through requester 0
    for (int t = 0; t < 9; t++) begin
      set_req(0, dir_a[t], dir_b[t], dir_s[t]);
      wait_hs(0);
      idle(3);
    end

    // All four valid continuously
    for (int i = 0; i < NREQ; i++) set_rnd(i);
    for (int k = 0; k < 12; k++) begin
      tick(hs);
      for (int i = 0; i < NREQ; i++) if (hs[i]) set_rnd(i);
    end
    req_valid = '0;
    idle(4);

    // Back-pressure in RESP, then regrant of req2 on release
    rsp_ready = 1'b0;
    set_req(0, 32'd3, 32'd9, 1'b0);
    wait_hs(0);
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick(hs);
      n++;
    end
    if (!rsp_valid) chk("rsp_valid_timeout", 64'd0, 64'd1);
    idle(5);
    set_req(2, 32'hFFFF_FFF0, 32'd4, 1'b1);
    rsp_ready = 1'b1;
    wait_hs(2);
    idle(4);

    // Reset while in EXEC drops the op
    set_req(3, 32'd1, 32'd2, 1'b0);
    wait_hs(3);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    set_req(1, 32'd10, 32'd2, 1'b0);
    wait_hs(1);
    idle(4);

    // Randomized traffic with back-pressure and legal withdrawals
    for (int k = 0; k < 400; k++) begin
      tick(hs);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i]) begin
          if (hs[i]) begin
            if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
            else set_rnd(i);
          end else if ($urandom_range(0, 15) == 0) begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          set_rnd(i);
        end
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    idle(6);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
